// File: rtl/hilo_ctrl.sv
// hilo_ctrl: multiply sequencer and HI/LO register pair downstream of mult.
// Optional macro HILO_FWD_EN: done and the mult result are presented in the CAPTURE cycle.
module hilo_ctrl #(
    parameter int N         = 32,
    parameter int START_CYC = 2,
    parameter int MULT_LAT  = 34,
    parameter int CNT_W     = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         opStart,
    input  logic [N-1:0] opA,
    input  logic [N-1:0] opB,
    input  logic         mthi,
    input  logic         mtlo,
    input  logic [N-1:0] wrData,
    input  logic         mfSel,
    output logic [N-1:0] rdData,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] multSrcA,
    output logic [N-1:0] multSrcB,
    output logic         multCtrl,
    input  logic [N-1:0] multHi,
    input  logic [N-1:0] multLo,
    output logic [N-1:0] hiOut,
    output logic [N-1:0] loOut
);
    typedef enum logic [1:0] {IDLE, START, WAIT, CAPTURE} state_t;
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] LAT_LAST   = CNT_W'(MULT_LAT - 1);
    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [N-1:0] hi, lo;
    always_ff @(posedge clk)
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        case (state)
            IDLE:  state_nxt = opStart ? START : IDLE;
            START: begin
                state_nxt = cnt == START_LAST ? WAIT : START;
                cnt_nxt   = cnt == START_LAST ? '0 : cnt + CNT_W'(1);
            end
            WAIT:  begin
                state_nxt = cnt == LAT_LAST ? CAPTURE : WAIT;
                cnt_nxt   = cnt == LAT_LAST ? '0 : cnt + CNT_W'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end
    // multCtrl is registered off the next state so it rises with START and falls with WAIT
    always_ff @(posedge clk)
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            multSrcA <= '0;
            multSrcB <= '0;
            multCtrl <= 1'b0;
        end else begin
            multCtrl <= state_nxt == START;
            if (state == CAPTURE) begin
                hi <= multHi;
                lo <= multLo;
            end else if (state == IDLE) begin
                if (mthi) hi <= wrData;
                if (mtlo) lo <= wrData;
                if (opStart) begin
                    multSrcA <= opA;
                    multSrcB <= opB;
                end
            end
        end
    assign hiOut = hi;
    assign loOut = lo;
`ifdef HILO_FWD_EN
    assign busy   = state == START || state == WAIT;
    assign done   = state == CAPTURE;
    assign rdData = state == CAPTURE ? (mfSel ? multHi : multLo) : (mfSel ? hi : lo);
`else
    logic done_q;
    always_ff @(posedge clk)
        if (reset) done_q <= 1'b0;
        else done_q <= state == CAPTURE;
    assign busy   = state != IDLE;
    assign done   = done_q;
    assign rdData = mfSel ? hi : lo;
`endif
endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: randomized scoreboard bench for hilo_ctrl with a behavioural mult and HI/LO model.
module tb_hilo_ctrl;
    localparam int N         = 32;
    localparam int START_CYC = 2;
    localparam int MULT_LAT  = 34;
    localparam int OP_LEN    = START_CYC + MULT_LAT + 1;
`ifdef HILO_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int DONE_OFF = FWD ? OP_LEN - 1 : OP_LEN;

    logic clk = 1'b0, reset = 1'b1, opStart = 1'b0, mthi = 1'b0, mtlo = 1'b0, mfSel = 1'b0;
    logic [N-1:0] opA = '0, opB = '0, wrData = '0;
    logic [N-1:0] rdData, multSrcA, multSrcB, multHi, multLo, hiOut, loOut;
    logic busy, done, multCtrl;
    logic [2*N-1:0] junk = '0;
    int lo_cnt = 0;

    typedef struct {
        logic [N-1:0] hi;
        logic [N-1:0] lo;
        int cyc;
    } exp_t;
    exp_t exp_q[$];
    exp_t e_cur;
    logic [N-1:0] m_hi = '0, m_lo = '0, m_a = '0, m_b = '0, p_hi = '0, p_lo = '0, exp_rd;
    int op_left = 0, cyc = 0, n_chk = 0, n_err = 0;
    bit run = 1'b0;

    hilo_ctrl dut (
        .clk(clk), .reset(reset), .opStart(opStart), .opA(opA), .opB(opB),
        .mthi(mthi), .mtlo(mtlo), .wrData(wrData), .mfSel(mfSel), .rdData(rdData),
        .busy(busy), .done(done), .multSrcA(multSrcA), .multSrcB(multSrcB),
        .multCtrl(multCtrl), .multHi(multHi), .multLo(multLo), .hiOut(hiOut), .loOut(loOut)
    );

    always #5 clk = ~clk;

    function automatic logic [2*N-1:0] smul(input logic [N-1:0] a, input logic [N-1:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return sa * sb;
    endfunction

    // mult stand-in: the product is valid only MULT_LAT cycles after multCtrl falls, junk otherwise
    always @(posedge clk) begin
        lo_cnt <= multCtrl ? 0 : (lo_cnt > 999 ? lo_cnt : lo_cnt + 1);
        junk   <= {$urandom, $urandom};
    end
    assign {multHi, multLo} = lo_cnt == MULT_LAT ? smul(multSrcA, multSrcB) : junk;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: cycle %0d got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) if (run) begin
        chk("busy", N'(busy), N'(FWD ? op_left > 1 : op_left > 0));
        chk("multCtrl", N'(multCtrl), N'(op_left > OP_LEN - START_CYC));
        chk("hiOut", hiOut, m_hi);
        chk("loOut", loOut, m_lo);
        chk("multSrcA", multSrcA, m_a);
        chk("multSrcB", multSrcB, m_b);
        exp_rd = mfSel ? m_hi : m_lo;
        if (done) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL done: unexpected pulse at cycle %0d", cyc);
            end else begin
                e_cur = exp_q.pop_front();
                chk("done_cycle", N'(cyc), N'(e_cur.cyc));
                if (FWD) exp_rd = mfSel ? e_cur.hi : e_cur.lo;
            end
        end else if (exp_q.size() > 0 && cyc >= exp_q[0].cyc) begin
            n_chk++;
            n_err++;
            $display("FAIL done: missing pulse expected at cycle %0d", exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        chk("rdData", rdData, exp_rd);
    end

    // Drives one cycle of inputs, waits for the edge that samples them, then advances the model.
    task automatic step(input bit r, input bit st, input bit th, input bit tl, input bit sel,
                        input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] wd);
        reset = r; opStart = st; mthi = th; mtlo = tl; mfSel = sel;
        opA = a; opB = b; wrData = wd;
        @(posedge clk);
        cyc++;
        if (r) begin
            m_hi = '0; m_lo = '0; m_a = '0; m_b = '0;
            op_left = 0;
            exp_q.delete();
        end else if (op_left > 0) begin
            op_left--;
            if (op_left == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else begin
            if (th) m_hi = wd;
            if (tl) m_lo = wd;
            if (st) begin
                m_a = a;
                m_b = b;
                {p_hi, p_lo} = smul(a, b);
                op_left = OP_LEN;
                exp_q.push_back('{p_hi, p_lo, cyc + DONE_OFF});
            end
        end
        run = 1'b1;
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom), $urandom, $urandom, $urandom);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 26, 30, 0);
        repeat (40) idle();
        step(0, 1, 0, 0, 1, 32'hFFFF_FFF3, 13, 0);
        repeat (12) idle();
        step(0, 1, 0, 0, 0, 5, 7, 0);
        repeat (30) idle();
        step(0, 0, 1, 0, 1, 0, 0, 32'hDEAD_BEEF);
        step(0, 0, 0, 1, 1, 0, 0, 32'h1234_5678);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 3, 4, 0);
        repeat (5) idle();
        step(0, 0, 1, 1, 1, 0, 0, 32'h0000_CAFE);
        repeat (40) idle();
        step(0, 1, 0, 0, 0, 26, 30, 0);
        repeat (12) idle();
        step(1, 0, 0, 0, 0, 0, 0, 0);
        repeat (45) idle();
        step(0, 1, 1, 1, 1, 7, 9, 32'h0000_0055);
        repeat (DONE_OFF) idle();
        step(0, 1, 0, 0, 0, 100, 200, 0);
        repeat (40) idle();
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) == 0, 1'($urandom), $urandom, $urandom, $urandom);
        repeat (45) idle();
        chk("queue_drained", N'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
